// File: rtl/window_decision.sv
// rtl/window_decision.sv - windowed stress-decision controller between classifier and counter
// Optional feature macro: WINDOW_DECISION_DROP_CNT_EN (adds drop_count output)
module window_decision #(
  parameter int WIN_LEN = 8,
  parameter int THRESH  = 4
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic        enable,
  input  logic        trig_in,
  output logic        trig_out,
  output logic        init,
  input  logic [10:0] count,
  output logic        decision_valid,
  input  logic        decision_ready,
  output logic        stress,
  output logic [10:0] stress_count,
`ifdef WINDOW_DECISION_DROP_CNT_EN
  output logic [15:0] drop_count,
`endif
  output logic        busy
);

  localparam logic [10:0] LAST_SAMP = 11'(WIN_LEN - 1);
  localparam logic [10:0] THR       = 11'(THRESH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DECIDE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] samp_cnt_q, samp_cnt_d;
  logic        valid_q, valid_d;
  logic        stress_q, stress_d;
  logic [10:0] scount_q, scount_d;

  // State and decision registers
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= IDLE;
      samp_cnt_q <= 11'd0;
      valid_q    <= 1'b0;
      stress_q   <= 1'b0;
      scount_q   <= 11'd0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      valid_q    <= valid_d;
      stress_q   <= stress_d;
      scount_q   <= scount_d;
    end
  end

  // Next-state: window sequencing, decision capture in SETTLE, handshake in DECIDE
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    valid_d    = valid_q;
    stress_d   = stress_q;
    scount_d   = scount_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = CLEAR;
      end
      CLEAR: begin
        samp_cnt_d = 11'd0;
        state_d    = RUN;
      end
      RUN: begin
        if (trig_in) begin
          if (samp_cnt_q == LAST_SAMP) begin
            // Wrap to zero so the sample counter never exceeds WIN_LEN-1
            samp_cnt_d = 11'd0;
            state_d    = SETTLE;
          end else begin
            samp_cnt_d = samp_cnt_q + 11'd1;
          end
        end
      end
      SETTLE: begin
        // Counter has absorbed the final strobe by now, so count is the window total
        scount_d = count;
        stress_d = (count >= THR);
        valid_d  = 1'b1;
        state_d  = DECIDE;
      end
      DECIDE: begin
        if (valid_q && decision_ready) begin
          valid_d = 1'b0;
          state_d = enable ? CLEAR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WINDOW_DECISION_DROP_CNT_EN
  logic [15:0] drop_q;

  // Saturating count of strobes arriving while not accepting samples
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      drop_q <= 16'd0;
    end else if (trig_in && (state_q != RUN) && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`endif

  assign trig_out       = trig_in & (state_q == RUN);
  assign init           = (state_q == CLEAR);
  assign busy           = (state_q != IDLE);
  assign decision_valid = valid_q;
  assign stress         = stress_q;
  assign stress_count   = scount_q;

endmodule

// File: tb/tb_window_decision.sv
// tb/tb_window_decision.sv - randomized self-checking bench for window_decision
module tb_window_decision;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, trig_in, decision_ready;
  logic        trig_out, init, decision_valid, stress, busy;
  logic [10:0] count, stress_count;
  logic        cls;

  logic        en0, trig0, ready0;
  logic        trig_out0, init0, valid0, stress0, busy0;
  logic [10:0] zero11, sc0;

`ifdef WINDOW_DECISION_DROP_CNT_EN
  logic [15:0] drop_count, drop0;
`endif

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  window_decision #(.WIN_LEN(8), .THRESH(4)) u_dut (
    .clk(clk), .RESETn(rst_n), .enable(enable), .trig_in(trig_in),
    .trig_out(trig_out), .init(init), .count(count),
    .decision_valid(decision_valid), .decision_ready(decision_ready),
    .stress(stress), .stress_count(stress_count),
`ifdef WINDOW_DECISION_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .busy(busy)
  );

  window_decision #(.WIN_LEN(2), .THRESH(0)) u_dut_t0 (
    .clk(clk), .RESETn(rst_n), .enable(en0), .trig_in(trig0),
    .trig_out(trig_out0), .init(init0), .count(zero11),
    .decision_valid(valid0), .decision_ready(ready0),
    .stress(stress0), .stress_count(sc0),
`ifdef WINDOW_DECISION_DROP_CNT_EN
    .drop_count(drop0),
`endif
    .busy(busy0)
  );

  // Stand-in classification counter: cleared by init, adds the class bit per trig_out
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count <= 11'd0;
    else if (init)     count <= 11'd0;
    else if (trig_out) count <= count + {10'd0, cls};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drop();
`ifdef WINDOW_DECISION_DROP_CNT_EN
    check("drop_count", {16'd0, drop_count}, exp_drop);
`endif
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init && n < 20) begin
      tick();
      n++;
    end
    check("init_seen", {31'd0, init}, 32'd1);
  endtask

  // One full window: 8 strobes with class bits from cls_bits, then a handshake
  // after ready_delay cycles of back-pressure. drop_en lowers enable after the 3rd strobe.
  task automatic run_window(input logic [7:0] cls_bits, input int ready_delay, input bit drop_en);
    int exp_cnt;
    bit exp_stress;
    exp_cnt    = $countones(cls_bits);
    exp_stress = (exp_cnt >= 4);
    wait_init();
    tick();
    check("init_one_cycle", {31'd0, init}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      trig_in = 1'b1;
      cls     = cls_bits[i];
      #1;
      check("trig_out_run", {31'd0, trig_out}, 32'd1);
      tick();
      trig_in = 1'b0;
      check("valid_early", {31'd0, decision_valid}, 32'd0);
      if (drop_en && i == 2) enable = 1'b0;
      if (i < 7) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
      end
    end
    tick();
    check("valid_rise", {31'd0, decision_valid}, 32'd1);
    check("stress", {31'd0, stress}, {31'd0, exp_stress});
    check("stress_count", {21'd0, stress_count}, exp_cnt);
    for (int d = 0; d < ready_delay; d++) begin
      trig_in = 1'($urandom_range(0, 1));
      decision_ready = 1'b0;
      #1;
      check("trig_out_blocked", {31'd0, trig_out}, 32'd0);
      tick();
      if (trig_in) exp_drop++;
      trig_in = 1'b0;
      check("valid_held", {31'd0, decision_valid}, 32'd1);
      check("count_held", {21'd0, stress_count}, exp_cnt);
    end
    decision_ready = 1'b1;
    tick();
    decision_ready = 1'b0;
    check("valid_fall", {31'd0, decision_valid}, 32'd0);
    check("stress_kept", {31'd0, stress}, {31'd0, exp_stress});
    check_drop();
    if (drop_en) begin
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_no_init", {31'd0, init}, 32'd0);
      tick();
      check("idle_stays", {31'd0, busy}, 32'd0);
      enable = 1'b1;
    end else begin
      check("next_init", {31'd0, init}, 32'd1);
      check("next_busy", {31'd0, busy}, 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; trig_in = 1'b0; decision_ready = 1'b0; cls = 1'b0;
    en0 = 1'b0; trig0 = 1'b0; ready0 = 1'b0; zero11 = 11'd0;
    tick();
    tick();
    check("rst_init", {31'd0, init}, 32'd0);
    check("rst_valid", {31'd0, decision_valid}, 32'd0);
    check("rst_stress", {31'd0, stress}, 32'd0);
    check("rst_scount", {21'd0, stress_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    trig_in = 1'b1;
    #1;
    check("rst_trig_out", {31'd0, trig_out}, 32'd0);
    trig_in = 1'b0;
    check_drop();
    rst_n = 1'b1;
    tick();
    check("post_rst_init", {31'd0, init}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd1);

    run_window(8'b0001_1111, 0, 1'b0);
    run_window(8'b0000_0111, 10, 1'b0);
    run_window(8'b1010_1010, 2, 1'b0);
    run_window(8'b1100_0000, 1, 1'b1);
    for (int w = 0; w < 6; w++) begin
      run_window(8'($urandom), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
    end

    // Abandon a window with a reset after 5 strobes
    wait_init();
    tick();
    for (int i = 0; i < 5; i++) begin
      trig_in = 1'b1;
      cls = 1'b1;
      tick();
      trig_in = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    exp_drop = 0;
    check("midrst_valid", {31'd0, decision_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_scount", {21'd0, stress_count}, 32'd0);
    check_drop();
    tick();
    tick();
    check("midrst_hold", {31'd0, decision_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    run_window(8'($urandom), $urandom_range(1, 5), 1'b0);

    // THRESH=0 instance: zero count still declares stress
    en0 = 1'b1;
    begin
      int n = 0;
      while (!init0 && n < 20) begin
        tick();
        n++;
      end
    end
    check("t0_init", {31'd0, init0}, 32'd1);
    tick();
    trig0 = 1'b1;
    tick();
    tick();
    trig0 = 1'b0;
    check("t0_valid_early", {31'd0, valid0}, 32'd0);
    tick();
    check("t0_valid", {31'd0, valid0}, 32'd1);
    check("t0_stress", {31'd0, stress0}, 32'd1);
    check("t0_scount", {21'd0, sc0}, 32'd0);
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    check("t0_valid_fall", {31'd0, valid0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
